prim_clock_gate_ctrl: RTL and testbench
=======================================

// Module: prim_clock_gate_ctrl
// PURPOSE
//  Enable-side controller for the FPGA/ASIC clock-gating primitive: decides when a
//  downstream clock domain may be gated and drives the gate's enable input.
//  Watches an activity signal and counts consecutive idle cycles.
//  Runs a quiesce req/ack handshake with the gated domain, gates the clock, and
//  restores it on a wake request with a fixed settle delay.
//  Sits in the always-on domain; clk_en_o feeds the gate en_i (test_en_i is ORed at the gate).
// PARAMETERS
//  IdleCycles  default 16  consecutive idle cycles before a quiesce request; legal >= 1
//  WakeCycles  default 2   cycles clock runs after ungating before wake_done_o; legal >= 1
//  IdleW       default $clog2(IdleCycles+1)  idle counter width (derived, do not override)
//  WakeW       default $clog2(WakeCycles+1)  wake counter width (derived, do not override)
// PORTS
//  clk_i            in   1  free-running (ungated) clock
//  rst_i            in   1  reset
//  auto_gate_en_i   in   1  1 = automatic gating permitted
//  busy_i           in   1  gated domain has work pending/in flight
//  wake_i           in   1  wake request (level or pulse)
//  quiesce_ack_i    in   1  gated domain has drained and accepts clock stop
//  clk_en_o         out  1  enable to clock gate (1 = clock runs)
//  quiesce_req_o    out  1  request to gated domain to drain / remain stopped
//  gated_o          out  1  status: clock currently gated
//  wake_done_o      out  1  one-cycle pulse: clock restored and settled
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - All outputs registered. Reset values:
//    - clk_en_o=1, quiesce_req_o=0, gated_o=0, wake_done_o=0.
//    - State RUN; both counters 0.
//  - Reset mid-operation (any state): next cycle is RUN with clock enabled and req dropped.
//  - FSM states: RUN, REQ, GATED, WAKE.
//  - RUN (en=1, req=0):
//    - idle = auto_gate_en_i & ~busy_i.
//    - idle: idle_cnt += 1, saturating at IdleCycles; else idle_cnt := 0.
//    - idle with idle_cnt==IdleCycles-1 -> REQ.
//    - So req rises on the clock edge that ends the IdleCycles-th consecutive idle cycle.
//    - wake_i in RUN is ignored.
//  - REQ (en=1, req=1):
//    - abort = busy_i | wake_i | ~auto_gate_en_i.
//    - abort -> RUN; req drops, idle_cnt:=0.
//    - else quiesce_ack_i -> GATED.
//    - Abort has priority over a same-cycle ack.
//  - GATED (en=0, req=1, gated=1):
//    - clk_en_o falls one cycle after the accepted ack.
//    - wake_i | ~auto_gate_en_i -> WAKE.
//    - busy_i and quiesce_ack_i are ignored.
//  - WAKE (en=1, req=1, gated=0):
//    - wake_cnt counts 0..WakeCycles-1, then -> RUN.
//    - On that transition: req:=0 and wake_done_o pulses for exactly one cycle.
//    - wake_i, busy_i and ack are ignored; reset is the only way out early.
//  - quiesce_ack_i outside REQ has no effect.
//  - quiesce_req_o stays high from REQ through WAKE, so the gated domain cannot restart early.
//  - No combinational path from any input to any output.
// TESTING
//  1. Reset, then auto_gate_en_i=1, busy_i=0 held, IdleCycles=16:
//     - quiesce_req_o rises exactly 16 cycles after reset release.
//     - clk_en_o stays 1.
//  2. Idle 10 cycles, then busy_i=1 for 1 cycle, then idle:
//     - Counter restarts; req rises 16 cycles after busy_i falls.
//  3. In REQ, assert busy_i and quiesce_ack_i in the same cycle:
//     - Back to RUN, req=0 next cycle, clk_en_o never drops.
//  4. REQ + ack alone:
//     - Next cycle clk_en_o=0, gated_o=1.
//     - Pulse wake_i: clk_en_o=1 next cycle.
//     - WakeCycles=2 -> wake_done_o pulses 2 cycles later, req=0 with it.
//  5. In GATED, assert rst_i for 1 cycle:
//     - Next cycle clk_en_o=1, req=0, gated_o=0, state RUN.
//     - The idle count restarts from 0.
//  6. In GATED, drop auto_gate_en_i:
//     - Enters WAKE, then RUN.
//     - With auto_gate_en_i held 0, req never reasserts.

Source files
------------

// File: rtl/prim_clock_gate_ctrl.sv
// Enable-side controller for a clock-gating cell: detects sustained idleness, runs a
// quiesce req/ack handshake, gates the clock, and restores it with a fixed settle delay.
module prim_clock_gate_ctrl #(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2,
  parameter int IdleW      = $clog2(IdleCycles + 1),
  parameter int WakeW      = $clog2(WakeCycles + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic auto_gate_en_i,
  input  logic busy_i,
  input  logic wake_i,
  input  logic quiesce_ack_i,
  output logic clk_en_o,
  output logic quiesce_req_o,
  output logic gated_o,
  output logic wake_done_o
);

  typedef enum logic [1:0] {RUN, REQ, GATED, WAKE} state_e;

  localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleCycles - 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(IdleCycles);
  localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);

  state_e           state_q, state_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
  logic             wake_done_d;
  logic             idle;
  logic             abort;

  assign idle  = auto_gate_en_i & ~busy_i;
  assign abort = busy_i | wake_i | ~auto_gate_en_i;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = '0;
    wake_cnt_d  = '0;
    wake_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (idle) begin
          idle_cnt_d = (idle_cnt_q == IdleMax) ? IdleMax : idle_cnt_q + IdleW'(1);
          if (idle_cnt_q == IdleLast) begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Abort wins over a same-cycle ack so the domain never stops while it has work.
        if (abort) begin
          state_d = RUN;
        end else if (quiesce_ack_i) begin
          state_d = GATED;
        end
      end
      GATED: begin
        if (wake_i || !auto_gate_en_i) begin
          state_d = WAKE;
        end
      end
      WAKE: begin
        if (wake_cnt_q == WakeLast) begin
          state_d     = RUN;
          wake_done_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + WakeW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are registered copies of the next-state decode, so nothing is combinational to a pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      idle_cnt_q    <= '0;
      wake_cnt_q    <= '0;
      clk_en_o      <= 1'b1;
      quiesce_req_o <= 1'b0;
      gated_o       <= 1'b0;
      wake_done_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      clk_en_o      <= (state_d != GATED);
      quiesce_req_o <= (state_d != RUN);
      gated_o       <= (state_d == GATED);
      wake_done_o   <= wake_done_d;
    end
  end

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Table-driven bench for prim_clock_gate_ctrl: expected outputs are queued as each
// vector is driven and popped when the outputs settle after the next clock edge.
module tb_prim_clock_gate_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic auto_gate_en_i = 1'b0;
  logic busy_i = 1'b0;
  logic wake_i = 1'b0;
  logic quiesce_ack_i = 1'b0;
  logic clk_en_o, quiesce_req_o, gated_o, wake_done_o;

  prim_clock_gate_ctrl #(.IdleCycles(16), .WakeCycles(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .auto_gate_en_i (auto_gate_en_i),
    .busy_i         (busy_i),
    .wake_i         (wake_i),
    .quiesce_ack_i  (quiesce_ack_i),
    .clk_en_o       (clk_en_o),
    .quiesce_req_o  (quiesce_req_o),
    .gated_o        (gated_o),
    .wake_done_o    (wake_done_o)
  );

  always #5 clk_i = ~clk_i;

  // stim = {rst, auto_gate_en, busy, wake, ack}; expect = {clk_en, req, gated, wake_done}
  typedef struct {
    string      name;
    logic [4:0] stim;
    logic [3:0] expect_out;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] expect_out;
  } sb_t;

  vec_t vecs[$];
  sb_t  scoreboard[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [4:0] S_RST   = 5'b10000;
  localparam logic [4:0] S_IDLE  = 5'b01000;
  localparam logic [4:0] S_BUSY  = 5'b01100;
  localparam logic [4:0] S_WAKE  = 5'b01010;
  localparam logic [4:0] S_ACK   = 5'b01001;
  localparam logic [4:0] S_NOAUT = 5'b00000;

  localparam logic [3:0] O_RUN   = 4'b1000;
  localparam logic [3:0] O_REQ   = 4'b1100;
  localparam logic [3:0] O_GATED = 4'b0110;
  localparam logic [3:0] O_DONE  = 4'b1001;

  task automatic addVec(input string name, input logic [4:0] stim, input logic [3:0] exp_out);
    vec_t v;
    v.name       = name;
    v.stim       = stim;
    v.expect_out = exp_out;
    vecs.push_back(v);
  endtask

  task automatic addRun(input string name, input logic [4:0] stim, input logic [3:0] exp_out,
                        input int n);
    for (int i = 0; i < n; i++) addVec(name, stim, exp_out);
  endtask

  task automatic applyStimulus(input vec_t v);
    sb_t e;
    {rst_i, auto_gate_en_i, busy_i, wake_i, quiesce_ack_i} = v.stim;
    e.name       = v.name;
    e.expect_out = v.expect_out;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    sb_t        e;
    logic [3:0] got;
    got = {clk_en_o, quiesce_req_o, gated_o, wake_done_o};
    total++;
    if (scoreboard.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty: got en/req/gated/done=%b, required an expected entry", got);
    end else begin
      e = scoreboard.pop_front();
      if (got !== e.expect_out) begin
        bad++;
        $display("[TB] FAIL %s at %0t: got en/req/gated/done=%b required %b",
                 e.name, $time, got, e.expect_out);
      end
    end
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    @(posedge clk_i);
    #1;
    checkOutput();
  endtask

  task automatic stepRaw(input string name, input logic [4:0] stim, input logic [3:0] exp_out);
    vec_t v;
    v.name       = name;
    v.stim       = stim;
    v.expect_out = exp_out;
    step(v);
  endtask

  initial begin
    // Idle detection from reset: req on the 16th idle edge, clock never stops.
    addVec("reset",            S_RST,  O_RUN);
    addRun("idle_count",       S_IDLE, O_RUN, 15);
    addVec("req_rise_16",      S_IDLE, O_REQ);
    addVec("req_hold_no_ack",  S_IDLE, O_REQ);
    addVec("abort_busy_ack",   5'b01101, O_RUN);
    // Busy for one cycle restarts the idle count.
    addRun("idle_partial",     S_IDLE, O_RUN, 10);
    addVec("busy_blip",        S_BUSY, O_RUN);
    addRun("idle_recount",     S_IDLE, O_RUN, 15);
    addVec("req_after_busy",   S_IDLE, O_REQ);
    // Full gate / wake cycle; busy and ack ignored while gated.
    addVec("ack_gates",        S_ACK,  O_GATED);
    addVec("gated_busy_ign",   5'b01101, O_GATED);
    addVec("gated_idle",       S_IDLE, O_GATED);
    addVec("wake_pulse",       S_WAKE, O_REQ);
    addVec("wake_settle",      5'b01111, O_REQ);
    addVec("wake_done",        S_IDLE, O_DONE);
    addVec("done_one_cycle",   S_IDLE, O_RUN);
    // wake_i in RUN does not disturb the idle count.
    addRun("run_wake_ign",     S_WAKE, O_RUN, 14);
    addVec("req_again",        S_IDLE, O_REQ);
    addVec("abort_wake",       5'b01011, O_RUN);
    addRun("idle_to_req",      S_IDLE, O_RUN, 15);
    addVec("req_third",        S_IDLE, O_REQ);
    addVec("abort_noauto",     5'b00001, O_RUN);
    addRun("idle_to_req4",     S_IDLE, O_RUN, 15);
    addVec("req_fourth",       S_IDLE, O_REQ);
    addVec("ack_gates2",       S_ACK,  O_GATED);
    // Reset while gated restores the clock and restarts the idle count.
    addVec("rst_in_gated",     S_RST,  O_RUN);
    addRun("idle_after_rst",   S_IDLE, O_RUN, 15);
    addVec("req_after_rst",    S_IDLE, O_REQ);
    addVec("ack_gates3",       S_ACK,  O_GATED);
    // Dropping auto enable while gated forces a wake and keeps req low afterwards.
    addVec("noauto_wake",      S_NOAUT, O_REQ);
    addVec("noauto_settle",    S_NOAUT, O_REQ);
    addVec("noauto_done",      S_NOAUT, O_DONE);
    addRun("noauto_hold",      S_NOAUT, O_RUN, 20);
    addRun("ack_outside_req",  5'b00001, O_RUN, 3);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset during the wake settle period: no done pulse, straight back to RUN.
    for (int i = 0; i < 15; i++) stepRaw("seq_idle", S_IDLE, O_RUN);
    stepRaw("seq_req",        S_IDLE, O_REQ);
    stepRaw("seq_ack",        S_ACK,  O_GATED);
    stepRaw("seq_wake",       S_WAKE, O_REQ);
    stepRaw("seq_rst_wake",   S_RST,  O_RUN);
    stepRaw("seq_no_done",    S_IDLE, O_RUN);
    stepRaw("seq_no_done2",   S_IDLE, O_RUN);

    if (scoreboard.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries required 0", scoreboard.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
